// File: rtl/countdown_ms.sv
// Programmable millisecond countdown timer: load a ms value, start, decrements once per ms, flags expiry.
// Latency: all outputs registered, one cycle after the controlling input; no backpressure (strobes always accepted).
// Control priority per cycle is load > pause > start > prescaler tick.
module countdown_ms #(
    parameter int CLK_PER_MS = 100000,
    parameter int MS_W       = 11
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic [MS_W-1:0] load_ms,
    input  logic            start,
    input  logic            pause,
    output logic [MS_W-1:0] ms_remaining,
    output logic            running,
    output logic            expired,
    output logic            done
);

    localparam int              PS_W    = $clog2(CLK_PER_MS);
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(CLK_PER_MS - 1);

    typedef enum logic [1:0] {IDLE, RUN, PAUSED, EXPIRED} state_t;

    state_t          state, state_nxt;
    logic [PS_W-1:0] prescaler, prescaler_nxt;
    logic [MS_W-1:0] ms_nxt;
    logic            running_nxt, expired_nxt, done_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            prescaler    <= '0;
            ms_remaining <= '0;
            running      <= 1'b0;
            expired      <= 1'b0;
            done         <= 1'b0;
        end else begin
            state        <= state_nxt;
            prescaler    <= prescaler_nxt;
            ms_remaining <= ms_nxt;
            running      <= running_nxt;
            expired      <= expired_nxt;
            done         <= done_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        prescaler_nxt = prescaler;
        ms_nxt        = ms_remaining;
        if (load) begin
            // load overrides everything, including a tick due this cycle
            state_nxt     = IDLE;
            prescaler_nxt = '0;
            ms_nxt        = load_ms;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state_nxt = (ms_remaining == '0) ? EXPIRED : RUN;
                    end
                end
                RUN: begin
                    if (pause) begin
                        state_nxt = PAUSED;
                    end else if (prescaler == PS_LAST) begin
                        prescaler_nxt = '0;
                        if (ms_remaining <= MS_W'(1)) begin
                            ms_nxt    = '0;
                            state_nxt = EXPIRED;
                        end else begin
                            ms_nxt = ms_remaining - 1'b1;
                        end
                    end else begin
                        prescaler_nxt = prescaler + 1'b1;
                    end
                end
                PAUSED: begin
                    // prescaler stays frozen so resumed run time adds up exactly
                    if (!pause && start) begin
                        state_nxt = RUN;
                    end
                end
                EXPIRED: begin
                    prescaler_nxt = '0;
                    ms_nxt        = '0;
                end
            endcase
        end
    end

    always_comb begin
        running_nxt = (state_nxt == RUN);
        expired_nxt = (state_nxt == EXPIRED);
        done_nxt    = (state_nxt == EXPIRED) && (state != EXPIRED);
    end

endmodule
